// File: rtl/axi_imem_responder.sv
// -----------------------------------------------------------------------------
// axi_imem_responder
//
// AXI4 read-channel responder that fronts a synchronous single-port block RAM
// (one clock of read latency). It accepts one AR transaction at a time and
// returns arlen+1 beats of 32-bit data on the R channel. It supports INCR
// (address steps by 4 and wraps modulo 2^ADDR_WIDTH) and FIXED bursts.
// Misaligned addresses, sizes other than 4 bytes, and WRAP/reserved burst
// types still return the full beat count, with rdata=0 and rresp=SLVERR.
// Every output comes from a register, so no input reaches an output
// combinationally.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   ar*                AXI4 read-address channel (arcache/arlock/arprot/arqos
//                      are accepted but have no effect)
//   r*                 AXI4 read-data channel
//   mem_en/mem_addr    BRAM read enable and word address
//   mem_dout           BRAM read data, valid one clock after the mem_en edge
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axi_imem_responder #(
    parameter int ADDR_WIDTH = 15,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [1:0]            arburst,
    input  logic [3:0]            arcache,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic                  arlock,
    input  logic [2:0]            arprot,
    input  logic [3:0]            arqos,
    input  logic [2:0]            arsize,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [ID_WIDTH-1:0]   rid,
    output logic                  rlast,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    input  logic [31:0]           mem_dout
);

    typedef enum logic [1:0] {
        IDLE,  // waiting for AR
        RD,    // mem_en asserted for the current beat
        LAT,   // BRAM read latency
        RESP   // beat presented on R, waiting for rready
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic                  fixed_q, fixed_d;
    logic                  err_q, err_d;

    logic                  arready_d;
    logic [31:0]           rdata_d;
    logic [ID_WIDTH-1:0]   rid_d;
    logic                  rlast_d;
    logic [1:0]            rresp_d;
    logic                  rvalid_d;
    logic                  mem_en_d;
    logic [ADDR_WIDTH-3:0] mem_addr_d;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  req_err;
    logic                  last_beat;
    logic [7:0]            next_beat;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Sideband AR fields carry nothing this memory cares about.
    logic unused_inputs;
    assign unused_inputs = ^{arcache, arlock, arprot, arqos};

    assign ar_hs     = arvalid && arready;
    assign r_hs      = rvalid && rready;
    assign req_err   = (araddr[1:0] != 2'b00) || (arsize != 3'b010) || arburst[1];
    assign last_beat = (beat_q == len_q);
    assign next_beat = beat_q + 8'd1;
    // FIXED repeats the same word; INCR steps one word and wraps naturally.
    assign next_addr = fixed_q ? addr_q : addr_q + ADDR_WIDTH'(4);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        fixed_d    = fixed_q;
        err_d      = err_q;
        arready_d  = arready;
        rdata_d    = rdata;
        rid_d      = rid;
        rlast_d    = rlast;
        rresp_d    = rresp;
        rvalid_d   = rvalid;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr;

        unique case (state_q)
            IDLE: begin
                // arready stays low in the first cycle after reset and rises
                // at that cycle's end.
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    addr_d    = araddr;
                    len_d     = arlen;
                    beat_d    = 8'd0;
                    fixed_d   = (arburst == 2'b00);
                    err_d     = req_err;
                    rid_d     = arid;
                    if (req_err) begin
                        // Error beats skip the BRAM entirely.
                        rvalid_d = 1'b1;
                        rdata_d  = 32'd0;
                        rresp_d  = RESP_SLVERR;
                        rlast_d  = (arlen == 8'd0);
                        state_d  = RESP;
                    end else begin
                        mem_en_d   = 1'b1;
                        mem_addr_d = araddr[ADDR_WIDTH-1:2];
                        state_d    = RD;
                    end
                end
            end

            RD: begin
                state_d = LAT;
            end

            LAT: begin
                rdata_d  = mem_dout;
                rvalid_d = 1'b1;
                rresp_d  = RESP_OKAY;
                rlast_d  = last_beat;
                state_d  = RESP;
            end

            RESP: begin
                if (r_hs) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (last_beat) begin
                        arready_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        beat_d = next_beat;
                        addr_d = next_addr;
                        if (err_q) begin
                            // Next error beat follows back to back.
                            rvalid_d = 1'b1;
                            rdata_d  = 32'd0;
                            rresp_d  = RESP_SLVERR;
                            rlast_d  = (next_beat == len_q);
                        end else begin
                            mem_en_d   = 1'b1;
                            mem_addr_d = next_addr[ADDR_WIDTH-1:2];
                            state_d    = RD;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and output registers use non-blocking assignments so that
    // every register samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            fixed_q  <= 1'b0;
            err_q    <= 1'b0;
            arready  <= 1'b0;
            rdata    <= '0;
            rid      <= '0;
            rlast    <= 1'b0;
            rresp    <= RESP_OKAY;
            rvalid   <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            fixed_q  <= fixed_d;
            err_q    <= err_d;
            arready  <= arready_d;
            rdata    <= rdata_d;
            rid      <= rid_d;
            rlast    <= rlast_d;
            rresp    <= rresp_d;
            rvalid   <= rvalid_d;
            mem_en   <= mem_en_d;
            mem_addr <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_axi_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_imem_responder
//
// Bench for axi_imem_responder. A BRAM model backs the DUT. Each issued AR
// pushes its expected beats (computed from the burst rules on the memory
// array) and its expected BRAM word addresses into queues. A monitor pops and
// compares them whenever the DUT completes an R handshake or asserts mem_en.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axi_imem_responder;

    localparam int AW    = 15;
    localparam int IW    = 4;
    localparam int DEPTH = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] araddr;
    logic [1:0]    arburst;
    logic [3:0]    arcache;
    logic [IW-1:0] arid;
    logic [7:0]    arlen;
    logic          arlock;
    logic [2:0]    arprot;
    logic [3:0]    arqos;
    logic [2:0]    arsize;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [IW-1:0] rid;
    logic          rlast;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          mem_en;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_dout;

    always #5 clk = ~clk;

    axi_imem_responder #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rstn(rstn),
        .araddr(araddr), .arburst(arburst), .arcache(arcache), .arid(arid),
        .arlen(arlen), .arlock(arlock), .arprot(arprot), .arqos(arqos),
        .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rlast(rlast), .rresp(rresp),
        .rvalid(rvalid), .rready(rready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    // Synchronous BRAM: data appears one clock after the enabled edge.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

    typedef struct packed {
        logic [31:0]   data;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [AW-3:0] addr_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    int            rmode   = 2;   // 0 always ready, 1 random, 2 manual, 3 pattern
    int            pat_idx = 0;
    logic [3:0]    pat     = 4'b1001;  // read LSB first: 1,0,0,1

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: expected beats straight from the burst rules.
    task automatic push_burst(input logic [AW-1:0] a, input logic [7:0] len,
                              input logic [IW-1:0] id, input logic [1:0] burst,
                              input logic [2:0] size);
        bit          err;
        int unsigned ba;
        beat_t       b;
        err = (a[1:0] != 2'b00) || (size != 3'b010) || burst[1];
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'b00) ba = a;
            else                ba = (int'(a) + 4 * i) % (1 << AW);
            b.data = err ? 32'd0 : mem[ba >> 2];
            b.id   = id;
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (!err) addr_q.push_back(AW'(ba) >> 2);
        end
    endtask

    // rready driver
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: rready = 1'b1;
            1: rready = 1'($urandom_range(0, 1));
            3: begin rready = pat[pat_idx % 4]; pat_idx++; end
            default: ;
        endcase
    end

    // Monitor: R beats, data stability under backpressure, BRAM addresses.
    bit    stall = 0;
    beat_t held;
    always @(negedge clk) begin
        if (!rstn) begin
            stall = 0;
        end else begin
            if (mem_en) begin
                if (addr_q.size() == 0) fail_now("mem_en_unexpected");
                else check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            end
            if (rvalid) begin
                beat_t e;
                check("arready_during_burst", 64'(arready), 64'd0);
                if (stall) begin
                    check("stable_rdata", 64'(rdata), 64'(held.data));
                    check("stable_rid",   64'(rid),   64'(held.id));
                    check("stable_rresp", 64'(rresp), 64'(held.resp));
                    check("stable_rlast", 64'(rlast), 64'(held.last));
                end
                if (rready) begin
                    stall = 0;
                    if (exp_q.size() == 0) fail_now("unexpected_beat");
                    else begin
                        e = exp_q.pop_front();
                        check("rdata", 64'(rdata), 64'(e.data));
                        check("rid",   64'(rid),   64'(e.id));
                        check("rresp", 64'(rresp), 64'(e.resp));
                        check("rlast", 64'(rlast), 64'(e.last));
                    end
                end else begin
                    stall     = 1;
                    held.data = rdata;
                    held.id   = rid;
                    held.resp = rresp;
                    held.last = rlast;
                end
            end else begin
                stall = 0;
            end
        end
    end

    // Drive AR until accepted; returns after the handshake edge.
    task automatic issue_ar(input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [IW-1:0] id, input logic [1:0] burst,
                            input logic [2:0] size);
        bit ok = 0;
        push_burst(a, len, id, burst, size);
        @(posedge clk);
        #1;
        araddr  = a;
        arlen   = len;
        arid    = id;
        arburst = burst;
        arsize  = size;
        arcache = 4'($urandom);
        arprot  = 3'($urandom);
        arqos   = 4'($urandom);
        arlock  = 1'($urandom);
        arvalid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        if (!ok) fail_now("ar_handshake_timeout");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic do_burst(input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [IW-1:0] id, input logic [1:0] burst,
                            input logic [2:0] size);
        int lat = 0;
        bit err;
        err = (a[1:0] != 2'b00) || (size != 3'b010) || burst[1];
        issue_ar(a, len, id, burst, size);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (rvalid) break;
        end
        check("first_beat_latency", 64'(lat), err ? 64'd1 : 64'd3);
        for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            fail_now("burst_drain_timeout");
            exp_q.delete();
            addr_q.delete();
        end
        @(posedge clk);
        #1;
        check("arready_after_burst", 64'(arready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        logic [1:0]    rb;
        logic [2:0]    rs;
        int            sel;
        bit            stale;

        rstn = 1'b0; arvalid = 1'b0; araddr = '0; arburst = 2'b01; arcache = '0;
        arid = '0; arlen = '0; arlock = 1'b0; arprot = '0; arqos = '0;
        arsize = 3'b010; rready = 1'b0;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem['h40 >> 2] = 32'h00A00093;
        mem['h100 >> 2] = 32'h11;
        mem['h104 >> 2] = 32'h22;
        mem['h108 >> 2] = 32'h33;
        mem['h10C >> 2] = 32'h44;

        #23;
        check("rst_arready",  64'(arready),  64'd0);
        check("rst_rvalid",   64'(rvalid),   64'd0);
        check("rst_rlast",    64'(rlast),    64'd0);
        check("rst_rresp",    64'(rresp),    64'd0);
        check("rst_rid",      64'(rid),      64'd0);
        check("rst_rdata",    64'(rdata),    64'd0);
        check("rst_mem_en",   64'(mem_en),   64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);

        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("arready_first_cycle", 64'(arready), 64'd0);
        @(posedge clk);
        #1;
        check("arready_rises", 64'(arready), 64'd1);

        rmode = 0;
        do_burst('h0040, 8'd0, 4'd3, 2'b01, 3'b010);      // single beat
        rmode = 3; pat_idx = 0;
        do_burst('h0100, 8'd3, 4'd5, 2'b01, 3'b010);      // INCR, backpressure
        rmode = 0;
        do_burst('h0200, 8'd2, 4'd7, 2'b00, 3'b010);      // FIXED
        do_burst('h7FFC, 8'd1, 4'd9, 2'b01, 3'b010);      // wrap
        do_burst('h0042, 8'd1, 4'd1, 2'b01, 3'b010);      // misaligned
        rmode = 1;
        do_burst('h0300, 8'd2, 4'd2, 2'b01, 3'b001);      // bad size
        do_burst('h0400, 8'd3, 4'd4, 2'b10, 3'b010);      // WRAP burst type
        do_burst(AW'($urandom) & ~AW'(3), 8'd255, 4'd6, 2'b01, 3'b010); // 256 beats

        for (int n = 0; n < 25; n++) begin
            ra  = AW'($urandom);
            if ($urandom_range(0, 5) != 0) ra[1:0] = 2'b00;
            sel = $urandom_range(0, 9);
            rb  = (sel < 4) ? 2'b00 : (sel < 9) ? 2'b01 : {1'b1, 1'($urandom)};
            rs  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
            rmode = $urandom_range(0, 1);
            do_burst(ra, 8'($urandom_range(0, 15)), IW'($urandom), rb, rs);
        end

        // Reset while beat 1 of a 4-beat burst waits on rready.
        rmode = 2;
        rready = 1'b1;
        issue_ar('h0500, 8'd3, 4'd8, 2'b01, 3'b010);
        for (int c = 0; c < 50 && exp_q.size() > 3; c++) @(negedge clk);
        @(posedge clk);
        #1;
        rready = 1'b0;
        for (int c = 0; c < 50 && !rvalid; c++) @(negedge clk);
        check("beat1_presented", 64'(rvalid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_rvalid",  64'(rvalid),  64'd0);
        check("midrst_arready", 64'(arready), 64'd0);
        check("midrst_mem_en",  64'(mem_en),  64'd0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn  = 1'b1;
        rmode = 0;
        @(posedge clk);
        #1;
        check("arready_after_reset", 64'(arready), 64'd1);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (rvalid || mem_en) stale = 1;
        end
        check("no_stale_beat", 64'(stale), 64'd0);
        do_burst('h0040, 8'd1, 4'd10, 2'b01, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
